// File: rtl/mac_accum_quant_pkg.sv
// Shared widths, tag/result types and the round-and-saturate helper for the
// quantising MAC stages.
package mac_accum_quant_pkg;

  localparam int PROD_W = 25;
  localparam int ACC_W  = 32;
  localparam int BIAS_W = 25;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 8;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic signed [BIAS_W-1:0] bias;
  } tag_t;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_ACCUM = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
  } quant_t;

  // One guard bit above ACC_W so the rounding add cannot wrap at the extremes.
  localparam logic signed [ACC_W:0] ROUND_ADD = (ACC_W+1)'(2 ** (SHIFT-1));
  localparam logic signed [ACC_W:0] SAT_MAX   = (ACC_W+1)'(2 ** (OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN   = (ACC_W+1)'(-(2 ** (OUT_W-1)));

  function automatic quant_t sat_round(input logic signed [ACC_W-1:0] fin);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] r;
    quant_t                q;
    ext = {fin[ACC_W-1], fin};
    r   = (ext + ROUND_ADD) >>> SHIFT;
    if (r > SAT_MAX) begin
      q.data = SAT_MAX[OUT_W-1:0];
      q.sat  = 1'b1;
    end else if (r < SAT_MIN) begin
      q.data = SAT_MIN[OUT_W-1:0];
      q.sat  = 1'b1;
    end else begin
      q.data = r[OUT_W-1:0];
      q.sat  = 1'b0;
    end
    return q;
  endfunction

endpackage

// File: rtl/mac_accum_quant_tag_delay.sv
// Tag shift register that travels in lockstep with the multiplier pipe, so
// the tail tag always describes the product currently on the multiplier output.
module mac_tag_delay
  import mac_accum_quant_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ce,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  // NOTE: every stage is reset, not only its valid bit's consumer, so products
  // still inside the multiplier at reset can never be mistaken for real terms.
  // NOTE: non-blocking assignments let every stage read its neighbour's old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_ce) begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mac_accum_quant.sv
// Dot-product accumulator behind a pipelined multiplier: accumulates products,
// adds bias, rounds/shifts and saturates to a 16-bit activation with backpressure.
module mac_accum_quant
  import mac_accum_quant_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [BIAS_W-1:0] in_bias,
  output logic                     in_ready,
  output logic                     mul_ce,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic                    w_ce;
  tag_t                    w_head;
  tag_t                    w_tail;
  acc_state_t              r_state;
  acc_state_t              w_state_next;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_load_acc;
  logic                    w_load_fin;
  logic signed [ACC_W-1:0] r_fin;
  logic                    r_fin_valid;
  quant_t                  w_q;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;
  logic                    r_out_valid;

  // A held result freezes the whole pipe, multiplier included; reset forces it open.
  assign w_ce     = ~r_out_valid | out_ready | reset;
  assign in_ready = w_ce;
  assign mul_ce   = w_ce;

  assign w_head = '{valid: in_valid & w_ce, last: in_last, bias: in_bias};

  mac_tag_delay #(
    .DEPTH (MUL_LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .reset (reset),
    .i_ce  (w_ce),
    .i_tag (w_head),
    .o_tag (w_tail)
  );

  always_ff @(posedge clk) begin
    if (reset)     r_state <= S_FIRST;
    else if (w_ce) r_state <= w_state_next;
  end

  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (w_tail.valid) w_state_next = w_tail.last ? S_FIRST : S_ACCUM;
  end

  always_comb begin
    w_base     = (r_state == S_FIRST) ? '0 : r_acc;
    w_sum      = w_base + ACC_W'(prod);
    w_load_acc = w_tail.valid & ~w_tail.last;
    w_load_fin = w_tail.valid & w_tail.last;
  end

  assign w_q = sat_round(r_fin);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_fin       <= '0;
      r_fin_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_ce) begin
      if (w_load_acc) r_acc <= w_sum;
      if (w_load_fin) r_fin <= w_sum + ACC_W'($signed(w_tail.bias));
      r_fin_valid <= w_load_fin;
      if (r_fin_valid) begin
        r_out_data  <= w_q.data;
        r_out_sat   <= w_q.sat;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mac_accum_quant.sv
// Directed bench for mac_accum_quant with a 3-stage clock-enabled multiplier model.
module tb_mac_accum_quant;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic signed [24:0] in_bias = '0;
  logic signed [15:0] in_a = '0;
  logic signed [8:0]  in_b = '0;
  logic               out_ready = 1'b1;
  logic               in_ready;
  logic               mul_ce;
  logic signed [24:0] prod;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               out_valid;

  logic signed [24:0] m_pipe [3] = '{default: '0};
  int                 cyc = 0;
  int                 total = 0;
  int                 pass = 0;
  logic signed [15:0] q_data [$];
  logic               q_sat [$];
  int                 q_cyc [$];

  mac_accum_quant #(.MUL_LATENCY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_bias   (in_bias),
    .in_ready  (in_ready),
    .mul_ce    (mul_ce),
    .prod      (prod),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mul_ce) begin
      m_pipe[0] <= 25'(in_a) * 25'(in_b);
      m_pipe[1] <= m_pipe[0];
      m_pipe[2] <= m_pipe[1];
    end
  end
  assign prod = m_pipe[2];

  // A result seen valid with ready at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sat.push_back(out_sat);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic signed [15:0] got_data(input int i);
    if (i < q_data.size()) return q_data[i];
    return 'x;
  endfunction

  function automatic logic got_sat(input int i);
    if (i < q_sat.size()) return q_sat[i];
    return 1'bx;
  endfunction

  function automatic int got_cyc(input int i);
    if (i < q_cyc.size()) return q_cyc[i];
    return -1000;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_sat.delete();
    q_cyc.delete();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_term(input logic signed [15:0] a, input logic signed [8:0] b,
                           input logic last, input logic signed [24:0] bias,
                           output int acc_cyc);
    logic ok;
    bit   done;
    int   c;
    done    = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_bias  = bias;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      ok = in_ready;
      c  = cyc;
      @(posedge clk);
      #1;
      if (ok) begin
        done    = 1'b1;
        acc_cyc = c;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k;
    k = 0;
    while (q_data.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    total++;
    if (q_data.size() < n) $display("FAIL wait_outputs got %0d results want %0d", q_data.size(), n);
    else pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
    total++; if (mul_ce !== 1'b1) $display("FAIL reset_mul_ce got %b want 1", mul_ce); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
    total++; if (out_data !== 16'sd0) $display("FAIL reset_out_data got %0d want 0", out_data); else pass++;
    total++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat got %b want 0", out_sat); else pass++;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int c;
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_term(16'sd256, 9'sd4, i == 3, 25'sd0, c);
    wait_outputs(1, 20);
    tick(6);
    total++; if (got_data(0) !== 16'sd16) $display("FAIL basic_data got %0d want 16", got_data(0)); else pass++;
    total++; if (got_sat(0) !== 1'b0) $display("FAIL basic_sat got %b want 0", got_sat(0)); else pass++;
    total++; if (got_cyc(0) - c !== 5) $display("FAIL basic_latency got %0d want 5", got_cyc(0) - c); else pass++;
    total++; if (q_data.size() !== 1) $display("FAIL basic_valid_cycles got %0d want 1", q_data.size()); else pass++;
  endtask

  task automatic test_rounding();
    int c;
    clear_q();
    send_term(16'sd128, 9'sd3, 1'b1, 25'sd0, c);
    send_term(16'sd383, 9'sd1, 1'b1, 25'sd0, c);
    send_term(-16'sd128, 9'sd3, 1'b1, 25'sd0, c);
    wait_outputs(3, 20);
    tick(6);
    total++; if (got_data(0) !== 16'sd2) $display("FAIL round_384 got %0d want 2", got_data(0)); else pass++;
    total++; if (got_data(1) !== 16'sd1) $display("FAIL round_383 got %0d want 1", got_data(1)); else pass++;
    total++; if (got_data(2) !== -16'sd1) $display("FAIL round_neg384 got %0d want -1", got_data(2)); else pass++;
    total++; if (got_sat(2) !== 1'b0) $display("FAIL round_sat got %b want 0", got_sat(2)); else pass++;
    total++; if (q_data.size() !== 3) $display("FAIL round_count got %0d want 3", q_data.size()); else pass++;
  endtask

  task automatic test_saturation();
    int c;
    clear_q();
    for (int i = 0; i < 8; i++) send_term(16'sd32767, 9'sd255, i == 7, 25'sd0, c);
    for (int i = 0; i < 4; i++) send_term(-16'sd32768, 9'sd255, i == 3, 25'sd0, c);
    wait_outputs(2, 20);
    tick(6);
    total++; if (got_data(0) !== 16'sd32767) $display("FAIL sat_pos_data got %0d want 32767", got_data(0)); else pass++;
    total++; if (got_sat(0) !== 1'b1) $display("FAIL sat_pos_flag got %b want 1", got_sat(0)); else pass++;
    total++; if (got_data(1) !== -16'sd32768) $display("FAIL sat_neg_data got %0d want -32768", got_data(1)); else pass++;
    total++; if (got_sat(1) !== 1'b1) $display("FAIL sat_neg_flag got %b want 1", got_sat(1)); else pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    clear_q();
    send_term(16'sd256, 9'sd2, 1'b0, 25'sd999, c);
    send_term(16'sd256, 9'sd2, 1'b1, 25'sd256, c);
    send_term(16'sd256, 9'sd1, 1'b1, 25'sd256, c);
    wait_outputs(2, 20);
    tick(6);
    total++; if (got_data(0) !== 16'sd5) $display("FAIL b2b_first got %0d want 5", got_data(0)); else pass++;
    total++; if (got_data(1) !== 16'sd2) $display("FAIL b2b_second got %0d want 2", got_data(1)); else pass++;
    total++; if (got_cyc(1) - got_cyc(0) !== 1) $display("FAIL b2b_gap got %0d want 1", got_cyc(1) - got_cyc(0)); else pass++;
    total++; if (q_data.size() !== 2) $display("FAIL b2b_count got %0d want 2", q_data.size()); else pass++;
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b0;
    fork
      begin
        int c;
        send_term(16'sd256, 9'sd4, 1'b1, 25'sd0, c);
        for (int i = 0; i < 6; i++) send_term(16'sd256, 9'sd5, i == 5, 25'sd0, c);
      end
      begin
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
          tick(1);
          k++;
        end
        total++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid got %b want 1", out_valid); else pass++;
        for (int i = 0; i < 6; i++) begin
          total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); else pass++;
          total++; if (mul_ce !== 1'b0) $display("FAIL bp_mul_ce cycle %0d got %b want 0", i, mul_ce); else pass++;
          total++; if (out_data !== 16'sd4 || out_valid !== 1'b1)
            $display("FAIL bp_hold cycle %0d got %0d/%b want 4/1", i, out_data, out_valid);
          else pass++;
          tick(1);
        end
        total++; if (q_data.size() !== 0) $display("FAIL bp_no_handshake got %0d want 0", q_data.size()); else pass++;
        out_ready = 1'b1;
      end
    join
    wait_outputs(2, 30);
    tick(6);
    total++; if (got_data(0) !== 16'sd4) $display("FAIL bp_result0 got %0d want 4", got_data(0)); else pass++;
    total++; if (got_data(1) !== 16'sd30) $display("FAIL bp_result1 got %0d want 30", got_data(1)); else pass++;
    total++; if (q_data.size() !== 2) $display("FAIL bp_count got %0d want 2", q_data.size()); else pass++;
  endtask

  task automatic test_reset_mid();
    int c;
    clear_q();
    out_ready = 1'b1;
    send_term(16'sd256, 9'sd4, 1'b0, 25'sd0, c);
    send_term(16'sd256, 9'sd4, 1'b0, 25'sd0, c);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", out_valid); else pass++;
    send_term(16'sd256, 9'sd4, 1'b1, 25'sd0, c);
    wait_outputs(1, 20);
    tick(8);
    total++; if (got_data(0) !== 16'sd4) $display("FAIL mid_reset_data got %0d want 4", got_data(0)); else pass++;
    total++; if (q_data.size() !== 1) $display("FAIL mid_reset_count got %0d want 1", q_data.size()); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/mac_accum_quant.md
Name: mac_accum_quant

Overview:
- Consumes the 25-bit signed products of the 16s x 9s pipelined DSP multiplier stage and accumulates them over a variable-length dot product.
- Adds a per-output bias, applies a rounding arithmetic right shift and saturates the result to a 16-bit activation.
- Tracks valid/last/bias tags through a delay line matched to the multiplier latency.
- Drives the multiplier's clock enable so that output backpressure stalls the whole MAC pipe.

Parameters:
- PROD_W, 25: product width from the multiplier (signed).
- ACC_W, 32: accumulator width (signed). No internal overflow detection; wraps modulo 2^ACC_W.
- BIAS_W, 25: bias width (signed), added at accumulator scale.
- OUT_W, 16: output activation width (signed).
- SHIFT, 8: rounding right-shift amount, 1..ACC_W-OUT_W.
- MUL_LATENCY, 3: clock-enabled edges from multiplier input sample to product valid at the multiplier output.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: an operand pair is being presented to the multiplier this cycle.
- in_last, in, 1: final term of the current dot product; qualified by in_valid.
- in_bias, in, BIAS_W: bias for the current output; sampled only with in_valid & in_last.
- in_ready, out, 1: term accepted when in_valid & in_ready.
- mul_ce, out, 1: clock enable to the multiplier; same signal as in_ready.
- prod, in, PROD_W: multiplier output dout.
- out_data, out, OUT_W: quantised result.
- out_sat, out, 1: out_data was clipped; qualified by out_valid.
- out_valid, out, 1: result available.
- out_ready, in, 1: downstream accepts when out_valid & out_ready.

Behaviour:
- Reset values: out_data=0, out_sat=0, out_valid=0, acc=0, first=1, fin_valid=0, all tag stages 0. reset=1 drives in_ready/mul_ce high.
- Reset mid-operation: the partial sum and all in-flight tags are discarded. Products still inside the multiplier are ignored because their tags are cleared.
- Stall rule: ce = ~out_valid | out_ready, combinational. in_ready = mul_ce = ce.
- Every register in this block updates only when ce=1, except reset.
- Tag pipe: MUL_LATENCY stages of {valid, last, bias}. Stage 0 loads {in_valid & ce, in_last, in_bias}. While ce=1 the tags shift in lockstep with the multiplier.
- A tag stage whose valid bit is set marks prod as valid at the tail.
- Accumulate, when the tail tag is valid and ce=1:
  - sum = (first ? 0 : acc) + sext(prod).
  - If last=0: acc <= sum, first <= 0.
  - If last=1: fin <= sum + sext(bias), fin_valid <= 1, first <= 1. acc is don't-care.
- fin_valid clears on the next ce cycle unless a new last term arrives in that cycle.
- Groups may be back-to-back: a last term followed by the next group's first term in the following cycle needs no bubble. A single-term group (in_last on the first term) is legal.
- Quantise, when fin_valid and ce=1:
  - r = (fin + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift with round-half-up.
  - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_data <= clipped value, out_sat <= (r != clipped), out_valid <= 1.
- When ce=1 and fin_valid=0: out_valid <= 0.
- While out_valid=1 and out_ready=0, out_data/out_sat/out_valid hold stable and ce=0 freezes everything upstream, so no data is lost or duplicated.
- Latency: last term accepted in cycle k (no stalls) gives out_valid=1 in cycle k+MUL_LATENCY+2, i.e. k+5 by default.
- Throughput: one term per cycle; one output per group.
- in_valid=0 cycles are bubbles; accumulation state is preserved across them.

Decomposition:
- Shared package holds the PROD_W/ACC_W/OUT_W/SHIFT defaults and a saturate-with-rounding function used by other quantising stages.
- One natural sub-module, mac_tag_delay: a MUL_LATENCY-deep tag shift register with ce and synchronous reset.
- Accumulate FSM and quantiser stay in the top module.

Test Plan:
- Four terms of 256x4 (prod=1024), bias=0, last on 4th, out_ready=1 -> out_data=16, out_sat=0, out_valid one cycle, 5 cycles after the last term.
- Rounding, SHIFT=8:
  - Single-term group with prod=384, bias=0 -> out_data=2.
  - Single-term group with prod=383 -> out_data=1.
  - prod=-384 -> out_data=-1 (half-up rounding).
- Saturation:
  - Eight terms of 32767x255 -> out_data=32767, out_sat=1.
  - Four terms of -32768x255 -> out_data=-32768, out_sat=1.
- Back-to-back groups [2 terms, 1 term] with bias=256 each, prods 512,512 then 256 -> outputs 5 then 2 on consecutive valid cycles, no bubble.
- Backpressure: out_ready=0 for 6 cycles while a second group streams in:
  - in_ready/mul_ce low throughout the stall.
  - First result held stable.
  - After release, both results emerge in order with the correct values.
- Assert reset for one cycle after 2 of 4 terms, then send a fresh 1-term group of prod=1024 -> out_data=4. No stale partial sum, no spurious out_valid.
